// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute and writeback in one clock.
// Instruction/data memories and register file are preloaded by hierarchical path.
module rv32i_imem #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];

    assign rdata = mem[addr];
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] reg_mem [32];

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_mem[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_mem[ra2];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) reg_mem[wa] <= wd;
    end
endmodule

module rv32i_dmem #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

module rv32i_single_cycle_core #(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    logic [31:0] pc, pc_next, pc_plus4, instr;
    logic [31:0] rs1_d, rs2_d, mem_rd, wb;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu_y;
    logic [6:0]  opcode;
    logic [2:0]  f3, alu_f3;
    logic        is_r, is_i, is_ld, is_st, is_br;
    logic        is_jal, is_jalr, is_lui, is_aui;
    logic        reg_we, mem_we, alu_sub, taken;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];

    assign is_r    = opcode == OP_R;
    assign is_i    = opcode == OP_I;
    assign is_ld   = opcode == OP_LD;
    assign is_st   = opcode == OP_ST;
    assign is_br   = opcode == OP_BR;
    assign is_jal  = opcode == OP_JAL;
    assign is_jalr = opcode == OP_JR;
    assign is_lui  = opcode == OP_LUI;
    assign is_aui  = opcode == OP_AUI;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    assign pc_plus4 = pc + 32'd4;

    rv32i_imem #(.WORDS(IMEM_WORDS), .AW(IW)) imem (
        .addr  (pc[IW+1:2]),
        .rdata (instr)
    );

    // Writes are gated by rst so nothing retires while reset is held.
    assign reg_we = rst & (is_r | is_i | is_ld | is_jal | is_jalr
                           | is_lui | is_aui);
    assign mem_we = rst & is_st;

    rv32i_regfile reg_file_inst (
        .clk (clk),
        .we  (reg_we),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .wa  (instr[11:7]),
        .wd  (wb),
        .rd1 (rs1_d),
        .rd2 (rs2_d)
    );

    // Non-ALU users of the adder (loads, stores, JALR) force an ADD.
    assign alu_f3  = (is_r | is_i) ? f3 : 3'b000;
    assign alu_sub = is_r & instr[30];
    assign op_b    = is_r ? rs2_d : (is_st ? imm_s : imm_i);

    always_comb begin
        alu_y = 32'd0;
        unique case (alu_f3)
            3'b000: alu_y = alu_sub ? rs1_d - op_b : rs1_d + op_b;
            3'b001: alu_y = rs1_d << op_b[4:0];
            3'b010: alu_y = {31'd0, $signed(rs1_d) < $signed(op_b)};
            3'b011: alu_y = {31'd0, rs1_d < op_b};
            3'b100: alu_y = rs1_d ^ op_b;
            3'b101: begin
                if (instr[30]) alu_y = $signed(rs1_d) >>> op_b[4:0];
                else           alu_y = rs1_d >> op_b[4:0];
            end
            3'b110: alu_y = rs1_d | op_b;
            3'b111: alu_y = rs1_d & op_b;
        endcase
    end

    rv32i_dmem #(.WORDS(DMEM_WORDS), .AW(DW)) data_mem_inst (
        .clk   (clk),
        .we    (mem_we),
        .addr  (alu_y[DW+1:2]),
        .wdata (rs2_d),
        .rdata (mem_rd)
    );

    always_comb begin
        taken = 1'b0;
        unique case (f3)
            3'b000:  taken = rs1_d == rs2_d;
            3'b001:  taken = rs1_d != rs2_d;
            3'b100:  taken = $signed(rs1_d) < $signed(rs2_d);
            3'b101:  taken = $signed(rs1_d) >= $signed(rs2_d);
            3'b110:  taken = rs1_d < rs2_d;
            3'b111:  taken = rs1_d >= rs2_d;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        wb = alu_y;
        unique case (1'b1)
            is_ld:             wb = mem_rd;
            is_jal | is_jalr:  wb = pc_plus4;
            is_lui:            wb = imm_u;
            is_aui:            wb = pc + imm_u;
            default:           wb = alu_y;
        endcase
    end

    always_comb begin
        pc_next = pc_plus4;
        unique case (1'b1)
            is_br & taken: pc_next = pc + imm_b;
            is_jal:        pc_next = pc + imm_j;
            is_jalr:       pc_next = alu_y & ~32'd1;
            default:       pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= pc_next;
    end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed-program bench for rv32i_single_cycle_core.
// Checks PC, registers and data memory after each retired instruction.
module tb_rv32i_single_cycle_core;
    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    rv32i_single_cycle_core dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [18];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;

        prog[0]  = 32'h0050_0093; // addi x1,x0,5
        prog[1]  = 32'hFFD0_0113; // addi x2,x0,-3
        prog[2]  = 32'h0020_81B3; // add  x3,x1,x2
        prog[3]  = 32'h4011_0233; // sub  x4,x2,x1
        prog[4]  = 32'h4012_52B3; // sra  x5,x4,x1
        prog[5]  = 32'h0020_B333; // sltu x6,x1,x2
        prog[6]  = 32'h00C0_2383; // lw   x7,12(x0)
        prog[7]  = 32'h0070_2823; // sw   x7,16(x0)
        prog[8]  = 32'h0100_00EF; // jal  x1,16
        prog[9]  = 32'h0070_0013; // addi x0,x0,7
        prog[10] = 32'h0000_0433; // add  x8,x0,x0
        prog[11] = 32'h0000_0463; // beq  x0,x0,8
        prog[12] = 32'h0000_8067; // jalr x0,0(x1)
        prog[13] = 32'h0000_1463; // bne  x0,x0,8
        prog[14] = 32'h1234_54B7; // lui  x9,0x12345
        prog[15] = 32'h0000_0000; // unknown opcode
        prog[16] = 32'h0000_1517; // auipc x10,1
        prog[17] = 32'h0000_006F; // jal  x0,0

        for (int i = 0; i < 1024; i++) dut.imem.mem[i] = 32'd0;
        for (int i = 0; i < 18; i++) dut.imem.mem[i] = prog[i];
        for (int i = 0; i < 32; i++) dut.reg_file_inst.reg_mem[i] = 32'd0;
        for (int i = 0; i < 1024; i++) dut.data_mem_inst.mem[i] = 32'd0;
        dut.reg_file_inst.reg_mem[8] = 32'hDEAD_BEEF;
        dut.data_mem_inst.mem[3]     = 32'h0000_00AB;

        #1;
        chk("reset_pc", dut.pc, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_hold_pc", dut.pc, 32'h0);
        chk("reset_no_wr_x1", dut.reg_file_inst.reg_mem[1], 32'h0);
        @(negedge clk);
        rst = 1'b1;

        step(); chk("addi_x1", dut.reg_file_inst.reg_mem[1], 32'd5);
        step(); chk("addi_x2", dut.reg_file_inst.reg_mem[2], 32'hFFFF_FFFD);
        step(); chk("add_x3", dut.reg_file_inst.reg_mem[3], 32'd2);
        step(); chk("sub_x4", dut.reg_file_inst.reg_mem[4], 32'hFFFF_FFF8);
        step(); chk("sra_x5", dut.reg_file_inst.reg_mem[5], 32'hFFFF_FFFF);
        step(); chk("sltu_x6", dut.reg_file_inst.reg_mem[6], 32'd1);
        step(); chk("lw_x7", dut.reg_file_inst.reg_mem[7], 32'h0000_00AB);
        step(); chk("sw_mem4", dut.data_mem_inst.mem[4], 32'h0000_00AB);
        chk("pc_0x20", dut.pc, 32'h20);
        step(); chk("jal_x1", dut.reg_file_inst.reg_mem[1], 32'h24);
        chk("jal_pc", dut.pc, 32'h30);
        step(); chk("jalr_pc", dut.pc, 32'h24);
        step(); chk("x0_kept", dut.reg_file_inst.reg_mem[0], 32'h0);
        step(); chk("add_x8_x0", dut.reg_file_inst.reg_mem[8], 32'h0);
        step(); chk("beq_taken_pc", dut.pc, 32'h34);
        step(); chk("bne_fall_pc", dut.pc, 32'h38);
        step(); chk("lui_x9", dut.reg_file_inst.reg_mem[9], 32'h1234_5000);
        step(); chk("nop_pc", dut.pc, 32'h40);
        step(); chk("auipc_x10", dut.reg_file_inst.reg_mem[10], 32'h0000_1040);
        chk("nop_no_wr_x0", dut.reg_file_inst.reg_mem[0], 32'h0);
        step(); chk("halt_pc", dut.pc, 32'h44);
        step(); chk("halt_pc2", dut.pc, 32'h44);

        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_pc", dut.pc, 32'h0);
        chk("rst_keep_x9", dut.reg_file_inst.reg_mem[9], 32'h1234_5000);
        chk("rst_keep_mem4", dut.data_mem_inst.mem[4], 32'h0000_00AB);
        step();
        step();
        chk("rst_no_wr_x1", dut.reg_file_inst.reg_mem[1], 32'h24);
        chk("rst_pc_held", dut.pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("restart_pc", dut.pc, 32'h4);
        chk("restart_x1", dut.reg_file_inst.reg_mem[1], 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32i_single_cycle_core.md
Name: rv32i_single_cycle_core

Overview:
- Single-cycle RV32I integer core. Fetches, decodes, executes and writes back one instruction per clock.
- Top-level of the CPU: contains instruction memory, register file, ALU, immediate generator, branch comparator and data memory.
- Its only ports are clock and reset. Architectural state is observed hierarchically.
- Memories and register file are preloaded at time 0 through fixed hierarchical array paths.

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024, data memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value held during reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.

Behaviour:
- Hierarchy contract (bench loads these by path):
  - instance imem with array mem [IMEM_WORDS] x 32, hex-loaded.
  - instance reg_file_inst with array reg_mem [32] x 32, binary-loaded.
  - instance data_mem_inst with array mem [DMEM_WORDS] x 32, binary-loaded.
- Reset (rst low, async): PC = RESET_PC. Register file and memories are not cleared, so preloaded contents survive reset. No writes occur while rst is low.
- Fetch: instr = imem.mem[PC[log2(IMEM_WORDS)+1:2]], combinational. Index wraps modulo depth; PC[1:0] is ignored.
- Register file:
  - 2 combinational read ports, 1 write port written on posedge when RegWrite is set.
  - x0 always reads 0; writes to x0 are discarded.
  - Same-cycle read of a register being written returns the old value.
- Supported instructions:
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Memory: LW, SW.
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Jumps and upper-immediate: JAL, JALR, LUI, AUIPC.
- Immediates: sign-extended per RV32I I/S/B/U/J formats. B and J immediates have bit0 = 0.
- Arithmetic: 32-bit, wrap-around on overflow, no traps. Shift amount is the low 5 bits. SRA/SRAI are arithmetic.
- Data memory:
  - Word index = ALU result[log2(DMEM_WORDS)+1:2]; low 2 bits ignored, index wraps modulo depth.
  - Read is combinational; SW writes rs2 on posedge.
- Writeback mux:
  - ALU result for R/I-ALU.
  - Memory word for LW.
  - PC+4 for JAL/JALR.
  - Immediate for LUI.
  - PC+imm for AUIPC.
- Next PC:
  - Taken branch: PC+immB.
  - JAL: PC+immJ.
  - JALR: (rs1+immI) & ~1.
  - Otherwise: PC+4.
- Unknown opcode: executes as NOP (no register or memory write), PC+4.
- Latency: every instruction completes in exactly one cycle. Results are visible in reg_mem or mem after the rising edge that ends the instruction's cycle.

Test Plan:
- Reset mid-run: pull rst low asynchronously between edges -> PC = 0 immediately; reg_mem and data memory unchanged; execution restarts at word 0 after release.
- ALU sequence, one result per cycle:
  - ADDI x1,x0,5 and ADDI x2,x0,-3.
  - ADD x3,x1,x2 -> x3 = 2.
  - SUB x4,x2,x1 -> x4 = 0xFFFFFFF8.
  - SRA x5,x4,x1 -> x5 = 0xFFFFFFFF.
  - SLTU x6,x1,x2 -> x6 = 1.
- Memory:
  - Preload data_mem_inst.mem[3] = 0x0000_00AB; LW x7,12(x0) -> x7 = 0xAB.
  - SW x7,16(x0) -> mem[4] = 0xAB on the next edge.
- x0 protection: ADDI x0,x0,7 -> x0 still reads 0; dependent ADD x8,x0,x0 -> x8 = 0.
- Branch and jump:
  - BEQ with equal operands and imm = 8 -> PC advances by 8, skipping one instruction.
  - BNE with equal operands -> PC+4.
  - JAL x1,16 at PC 0x20 -> x1 = 0x24, PC = 0x30.
  - JALR x0,0(x1) -> PC = 0x24.
- Upper immediates: LUI x9,0x12345 -> x9 = 0x12345000; AUIPC x10,1 at PC 0x40 -> x10 = 0x1040.
